// File: rtl/request_encoder_16_4_pkg.sv
// Shared constants and helpers for the 16-to-4 sequential request encoder.
// Index width is tied to the request count so every index is in range.
package request_encoder_16_4_pkg;

    localparam int REQ_N = 16;
    localparam int REQ_W = 4;

    typedef logic [REQ_N-1:0] req_vec_t;
    typedef logic [REQ_W-1:0] req_idx_t;

    function automatic req_vec_t onehot_w(input req_idx_t idx);
        req_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/request_encoder_16_4_priority.sv
// Combinational lowest-index-first priority encoder, 16 inputs to a 4-bit index.
// An all-zero input yields index 0 with any_o low.
import request_encoder_16_4_pkg::*;

module priority_encoder_16_4 (
    input  logic [REQ_N-1:0] vec_i,
    output logic [REQ_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        idx_o = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = REQ_N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = REQ_W'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/request_encoder_16_4.sv
// Sticky request collector that presents one pending request at a time as an
// index with a valid/ack handshake, lowest index first, without preemption.
import request_encoder_16_4_pkg::*;

module request_encoder_16_4 (
    input  logic             clk,
    input  logic             clr,
    input  logic [REQ_N-1:0] req_in,
    input  logic             ack,
    output logic [REQ_W-1:0] idx,
    output logic             valid,
    output logic             more,
    output logic [REQ_N-1:0] pending
);

    logic [REQ_N-1:0] pending_q, pending_d;
    logic [REQ_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

    logic             grant;
    logic [REQ_N-1:0] clr_mask;
    logic [REQ_W-1:0] enc_idx;
    logic             enc_any;

    assign grant    = valid_q & ack;
    assign clr_mask = grant ? onehot_w(idx_q) : '0;

    // Set dominates clear: a bit re-requested while being acked stays pending.
    assign pending_d = (pending_q & ~clr_mask) | req_in;

    priority_encoder_16_4 u_prio (
        .vec_i (pending_d),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        // A held presentation is never replaced by a newly arrived request.
        if (!valid_q || grant) begin
            idx_d   = enc_idx;
            valid_d = enc_any;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            pending_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
        end
    end

    assign idx     = idx_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign more    = valid_q & |(pending_q & ~onehot_w(idx_q));

endmodule

// File: tb/tb_request_encoder_16_4.sv
// Directed and randomized bench for request_encoder_16_4 using an expected-value queue.
module tb_request_encoder_16_4;

    logic        clk;
    logic        clr;
    logic [15:0] req_in;
    logic        ack;
    logic [3:0]  idx;
    logic        valid;
    logic        more;
    logic [15:0] pending;

    typedef struct {
        logic        v;
        logic [3:0]  i;
        logic        m;
        logic [15:0] p;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    logic        m_v;
    logic [3:0]  m_i;
    logic [15:0] m_p;

    request_encoder_16_4 dut (
        .clk     (clk),
        .clr     (clr),
        .req_in  (req_in),
        .ack     (ack),
        .idx     (idx),
        .valid   (valid),
        .more    (more),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_front();
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL sb_empty step=%0d observed size=0 expected >0", step_id);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (valid === e.v) else begin
                bad++;
                $error("FAIL valid step=%0d observed=%0b expected=%0b", e.id, valid, e.v);
            end
            total++;
            assert (idx === e.i) else begin
                bad++;
                $error("FAIL idx step=%0d observed=%0d expected=%0d", e.id, idx, e.i);
            end
            total++;
            assert (more === e.m) else begin
                bad++;
                $error("FAIL more step=%0d observed=%0b expected=%0b", e.id, more, e.m);
            end
            total++;
            assert (pending === e.p) else begin
                bad++;
                $error("FAIL pending step=%0d observed=%h expected=%h", e.id, pending, e.p);
            end
        end
    endtask

    task automatic step(input logic c, input logic [15:0] r, input logic a,
                        input logic ev, input logic [3:0] ei, input logic em,
                        input logic [15:0] ep);
        exp_t e;
        step_id++;
        clr    = c;
        req_in = r;
        ack    = a;
        e.v = ev; e.i = ei; e.m = em; e.p = ep; e.id = step_id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_front();
    endtask

    // Reference model: advances m_* by one clock edge for the given inputs.
    task automatic model_step(input logic c, input logic [15:0] r, input logic a);
        logic [15:0] np;
        logic        g;
        g  = m_v && a;
        np = m_p;
        if (g) np[m_i] = 1'b0;
        np = np | r;
        if (!c) begin
            m_p = '0; m_v = 1'b0; m_i = '0;
        end else begin
            if (!m_v || g) begin
                m_v = (np != 16'h0);
                m_i = '0;
                for (int k = 15; k >= 0; k--) if (np[k]) m_i = 4'(k);
            end
            m_p = np;
        end
    endtask

    function automatic logic model_more();
        logic [15:0] rest;
        rest = m_p;
        rest[m_i] = 1'b0;
        return m_v && (rest != 16'h0);
    endfunction

    initial begin
        clr = 1'b0; req_in = '0; ack = 1'b0;
        #1;

        // Reset holds everything at zero even with requests and ack asserted.
        step(1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
        step(1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
        step(1'b1, 16'hFFFF, 1'b1, 1'b1, 4'd0, 1'b1, 16'hFFFF);

        // Drain all sixteen with ack held high: one grant per cycle.
        for (int k = 1; k < 16; k++) begin
            step(1'b1, 16'h0000, 1'b1, 1'b1, 4'(k), (k < 15), 16'hFFFF << k);
        end
        step(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);

        // Single request.
        step(1'b1, 16'h0020, 1'b1, 1'b1, 4'd5, 1'b0, 16'h0020);
        step(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);

        // Multi-hot drain.
        step(1'b1, 16'h8101, 1'b1, 1'b1, 4'd0,  1'b1, 16'h8101);
        step(1'b1, 16'h0000, 1'b1, 1'b1, 4'd8,  1'b1, 16'h8100);
        step(1'b1, 16'h0000, 1'b1, 1'b1, 4'd15, 1'b0, 16'h8000);
        step(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 16'h0000);

        // Hold without preemption.
        step(1'b1, 16'h0100, 1'b0, 1'b1, 4'd8, 1'b0, 16'h0100);
        step(1'b1, 16'h0001, 1'b0, 1'b1, 4'd8, 1'b1, 16'h0101);
        step(1'b1, 16'h0000, 1'b0, 1'b1, 4'd8, 1'b1, 16'h0101);
        step(1'b1, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0001);
        step(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);

        // Simultaneous ack and re-request of the presented bit.
        step(1'b1, 16'h0008, 1'b0, 1'b1, 4'd3, 1'b0, 16'h0008);
        step(1'b1, 16'h0008, 1'b1, 1'b1, 4'd3, 1'b0, 16'h0008);
        step(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);

        // Ack while idle has no effect.
        step(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);

        // Reset mid-operation drops everything; index 5 never appears.
        step(1'b1, 16'hF0F0, 1'b0, 1'b1, 4'd4, 1'b1, 16'hF0F0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
        step(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
        step(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);

        // Randomized traffic against the reference model, starting from idle.
        m_v = 1'b0; m_i = '0; m_p = '0;
        for (int n = 0; n < 300; n++) begin
            logic        c;
            logic [15:0] r;
            logic        a;
            c = ($urandom_range(0, 39) != 0);
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 2) == 0) r = '0;
            a = ($urandom_range(0, 2) != 0);
            model_step(c, r, a);
            step(c, r, a, m_v, m_i, model_more(), m_p);
        end

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
